frame_painter: RTL and testbench
================================

# frame_painter

Back-buffer rasteriser that sits directly upstream of the VGA scan-out stage. It tracks which frame is on screen (`active_frame`) and writes only into the other frame. On every frame swap it clears the back buffer to a background colour, then accepts rectangle-fill commands and emits one pixel write per clock. Its write port drives the two frame stores that the scan-out stage reads.

## Interface
- `FRAME_W`, 160: frame width in stored pixels (640 × 25 %).
- `FRAME_H`, 120: frame height in stored pixels (480 × 25 %).
- `COORD_W`, 8: width of command coordinate/size fields; must satisfy 2^COORD_W ≥ max(FRAME_W, FRAME_H).
- `clk` in 1: 25 MHz pixel clock.
- `rst` in 1: asynchronous, active-high reset.
- `active_frame` in 1: frame being displayed (0 = A, 1 = B); produced in the refresh domain and synchronised internally.
- `bg_rgb` in 12: background colour {r,g,b} 4 bits each; sampled at start of each clear.
- `cmd_valid` in 1: rectangle command valid.
- `cmd_ready` out 1: block can accept a command.
- `cmd_x`, `cmd_y` in COORD_W: top-left corner in stored-pixel units.
- `cmd_w`, `cmd_h` in COORD_W: rectangle size in pixels.
- `cmd_rgb` in 12: fill colour.
- `wr_en` out 1: pixel write strobe.
- `wr_frame` out 1: target frame (always the back buffer).
- `wr_row` out $clog2(FRAME_H): write row.
- `wr_col` out $clog2(FRAME_W): write column.
- `wr_rgb` out 12: write colour.
- `busy` out 1: high in CLEAR or DRAW.
- `cmd_aborted` out 1: one-cycle pulse when a swap cuts off a DRAW.

## Operation
- `active_frame` passes through a 2-flop synchroniser and a third edge-detect flop, all reset to 0. `swap` is the toggle between stages 2 and 3.
- Back buffer: `target = ~active_sync`. It is latched when a CLEAR begins and held until the next CLEAR.
- States:
  - **CLEAR**: writes `bg_rgb` to every pixel, row-major from (0,0) to (FRAME_H-1, FRAME_W-1). `cmd_ready = 0`. After the last pixel, goes to IDLE.
  - **IDLE**: `cmd_ready = 1`. On `cmd_valid && cmd_ready`, the command is latched and clipped:
    - `x_end = min(cmd_x + cmd_w, FRAME_W)` and `y_end = min(cmd_y + cmd_h, FRAME_H)`, computed in COORD_W+1 bits so there is no wrap.
    - If `cmd_w == 0`, `cmd_h == 0`, `cmd_x >= FRAME_W` or `cmd_y >= FRAME_H`, the command is consumed and discarded; the block stays in IDLE with no writes.
    - Otherwise it goes to DRAW.
  - **DRAW**: writes `cmd_rgb` from (cmd_y, cmd_x) row-major to (y_end-1, x_end-1). `cmd_ready = 0`. After the last pixel, goes to IDLE.
- `swap` takes priority over everything in any state:
  - Enter CLEAR at pixel (0,0) with the new target.
  - If the state was DRAW, pulse `cmd_aborted`; the rest of that command is dropped.
  - A swap during CLEAR restarts the clear on the new target.
  - A command handshake in the same cycle as `swap` is not accepted (`cmd_ready` is forced low that cycle).
- Reset:
  - All outputs go to 0 and all counters to 0.
  - On release, the state is CLEAR with target = 1.
  - If `active_frame` is actually 1, the synchroniser produces a `swap` about 2 cycles later and the clear restarts on frame 0. This is intended.
  - Reset mid-DRAW or mid-CLEAR abandons the operation with no `cmd_aborted` pulse.

## Timing
- All outputs are registered.
- `wr_en` pulses form a contiguous burst of exactly one pixel per cycle, with no gaps.
- Command accepted at edge N: first write is visible after edge N+1. A clipped rectangle of cw×ch pixels occupies cycles N+1 … N+cw·ch. `cmd_ready` rises after edge N+cw·ch+1.
- Clear takes FRAME_W·FRAME_H = 19200 write cycles. `cmd_ready` rises the cycle after the last clear write.
- Swap latency: an `active_frame` change reaches `swap` in 2–3 clocks. The first clear write follows on the next edge.
- `wr_en` is low in IDLE. `wr_row`, `wr_col` and `wr_rgb` hold their last value when `wr_en` is low.

## Structure
- Shared package `painter_pkg` holds:
  - `rgb444_t` struct {r,g,b : 4 bits}, shared with the scan-out stage's pixel type.
  - state enum `{CLEAR, IDLE, DRAW}`.
  - default `FRAME_W` and `FRAME_H` constants.
- One sub-module, `bit_sync_edge`: 2-flop synchroniser plus toggle detect, async active-high reset, outputs the synchronised level and a 1-cycle `toggle` pulse.
- Row/column counters and clip logic stay in `frame_painter`.

## Test plan
1. Reset with `active_frame=0`, `bg_rgb=12'h00F`: exactly 19200 writes to frame 1, rows 0..119 and cols 0..159 each once, all `rgb=00F`. Then `cmd_ready=1`.
2. Command x=10, y=5, w=3, h=2, rgb=F00: 6 writes at (5,10..12) and (6,10..12) on consecutive cycles. `cmd_ready` low for exactly 7 cycles.
3. Command x=158, y=119, w=10, h=10: clipped to 2 writes, (119,158) and (119,159). Command w=0 or x=200: zero writes, `cmd_ready` stays high.
4. Toggle `active_frame` to 1 mid-DRAW: `cmd_aborted` pulses once, `wr_frame` becomes 0, a full 19200-write clear follows, and no further pixels of the aborted command are written.
5. Assert `rst` mid-clear, release with `active_frame=1`: outputs are 0 during reset, the clear starts on frame 1, then restarts on frame 0 within 4 cycles, and the final 19200 writes all target frame 0.
6. Hold `cmd_valid` high so that `swap` coincides with an IDLE cycle: that command is not accepted, and it is accepted after the clear completes.

Source files
------------

// File: rtl/frame_painter_pkg.sv
// Shared types and defaults for the back-buffer painter and the scan-out stage.
package painter_pkg;

    localparam int FRAME_W_DEF = 160;
    localparam int FRAME_H_DEF = 120;
    localparam int COORD_W_DEF = 8;

    // 4:4:4 pixel, identical to the scan-out stage's pixel type
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        DRAW  = 2'd2
    } painter_state_t;

endpackage

// File: rtl/frame_painter_if.sv
// Command and pixel-write bundle between the painter and its neighbours.
//
// Command handshake: a command transfers on a rising clk edge where
// cmd_valid and cmd_ready are both high. The source holds cmd_x/cmd_y/
// cmd_w/cmd_h/cmd_rgb stable while cmd_valid is high and may keep
// cmd_valid high for as long as it likes; cmd_ready never depends
// combinationally on cmd_valid. The write port has no back-pressure:
// every cycle with wr_en high is one pixel written to the frame stores.
interface frame_painter_if #(
    parameter int FRAME_W = painter_pkg::FRAME_W_DEF,
    parameter int FRAME_H = painter_pkg::FRAME_H_DEF,
    parameter int COORD_W = painter_pkg::COORD_W_DEF
);
    import painter_pkg::*;

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [COORD_W-1:0]         cmd_x;
    logic [COORD_W-1:0]         cmd_y;
    logic [COORD_W-1:0]         cmd_w;
    logic [COORD_W-1:0]         cmd_h;
    rgb444_t                    cmd_rgb;

    logic                       wr_en;
    logic                       wr_frame;
    logic [$clog2(FRAME_H)-1:0] wr_row;
    logic [$clog2(FRAME_W)-1:0] wr_col;
    rgb444_t                    wr_rgb;

    // Command source and frame-store side
    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_rgb,
        input  cmd_ready, wr_en, wr_frame, wr_row, wr_col, wr_rgb
    );

    // The painter itself
    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_rgb,
        output cmd_ready, wr_en, wr_frame, wr_row, wr_col, wr_rgb
    );

endinterface

// File: rtl/frame_painter_bit_sync_edge.sv
// Two-flop synchroniser for a slow level from another clock domain,
// with a third flop to flag each change of the synchronised level.
module bit_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic toggle
);

    logic meta;
    logic stable;
    logic prev;

    // Synchroniser chain plus history flop for change detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            stable <= 1'b0;
            prev   <= 1'b0;
        end else begin
            meta   <= d;
            stable <= meta;
            prev   <= stable;
        end
    end

    assign level  = stable;
    assign toggle = stable ^ prev;

endmodule

// File: rtl/frame_painter.sv
// Back-buffer rasteriser: clears the hidden frame on every swap, then
// fills clipped rectangles, one pixel write per clock.
module frame_painter
    import painter_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int FRAME_H = FRAME_H_DEF,
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           active_frame,
    input  rgb444_t        bg_rgb,
    frame_painter_if.slave bus,
    output logic           busy,
    output logic           cmd_aborted,
    output painter_state_t dbg_state
);

    localparam int ROW_W = $clog2(FRAME_H);
    localparam int COL_W = $clog2(FRAME_W);
    localparam int XW    = COORD_W + 1;
    localparam logic [COORD_W:0] FW = XW'(FRAME_W);
    localparam logic [COORD_W:0] FH = XW'(FRAME_H);

    painter_state_t   state, state_d;
    logic             active_sync, swap;
    logic             target;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col, col_start;
    logic [COORD_W:0] col_end, row_end;
    rgb444_t          paint_rgb;

    logic [COORD_W:0] col_nxt, row_nxt, x_sum, y_sum, x_end, y_end;
    logic             last_col, last_row, last_pix, at_origin;
    logic             pixel_go, accept, discard;

    logic             cmd_ready_q, cmd_ready_d;
    logic             wr_en_q, wr_en_d;
    logic             wr_frame_q, wr_frame_d;
    logic [ROW_W-1:0] wr_row_q, wr_row_d;
    logic [COL_W-1:0] wr_col_q, wr_col_d;
    rgb444_t          wr_rgb_q, wr_rgb_d;
    logic             busy_q, busy_d;
    logic             aborted_q, aborted_d;

    bit_sync_edge u_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (active_frame),
        .level  (active_sync),
        .toggle (swap)
    );

    // Scan position, clip limits and command handshake decode
    always_comb begin
        col_nxt   = XW'(col) + XW'(1);
        row_nxt   = XW'(row) + XW'(1);
        last_col  = (col_nxt == col_end);
        last_row  = (row_nxt == row_end);
        last_pix  = last_col && last_row;
        at_origin = (row == '0) && (col == '0);
        pixel_go  = ((state == CLEAR) || (state == DRAW)) && !swap;
        // Widened sums cannot wrap, so clipping is a plain min()
        x_sum     = XW'(bus.cmd_x) + XW'(bus.cmd_w);
        y_sum     = XW'(bus.cmd_y) + XW'(bus.cmd_h);
        x_end     = (x_sum > FW) ? FW : x_sum;
        y_end     = (y_sum > FH) ? FH : y_sum;
        discard   = (bus.cmd_w == '0) || (bus.cmd_h == '0) ||
                    (XW'(bus.cmd_x) >= FW) || (XW'(bus.cmd_y) >= FH);
        accept    = bus.cmd_valid && cmd_ready_q && (state == IDLE) && !swap;
    end

    // State register; reset releases straight into a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CLEAR;
        else     state <= state_d;
    end

    // Next state: a swap overrides everything and restarts the clear
    always_comb begin
        state_d = state;
        case (state)
            CLEAR:   if (last_pix) state_d = IDLE;
            IDLE:    if (accept && !discard) state_d = DRAW;
            DRAW:    if (last_pix) state_d = IDLE;
            default: state_d = CLEAR;
        endcase
        if (swap) state_d = CLEAR;
    end

    // Raster counters, clip window, target frame and fill colour
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row       <= '0;
            col       <= '0;
            col_start <= '0;
            col_end   <= FW;
            row_end   <= FH;
            target    <= 1'b1;
            paint_rgb <= '0;
        end else if (swap) begin
            row       <= '0;
            col       <= '0;
            col_start <= '0;
            col_end   <= FW;
            row_end   <= FH;
            target    <= ~active_sync;
        end else if (accept && !discard) begin
            row       <= bus.cmd_y[ROW_W-1:0];
            col       <= bus.cmd_x[COL_W-1:0];
            col_start <= bus.cmd_x[COL_W-1:0];
            col_end   <= x_end;
            row_end   <= y_end;
            paint_rgb <= bus.cmd_rgb;
        end else if (pixel_go) begin
            // The clear colour is captured on its first pixel
            if ((state == CLEAR) && at_origin) paint_rgb <= bg_rgb;
            if (last_col) begin
                col <= col_start;
                row <= row_nxt[ROW_W-1:0];
            end else begin
                col <= col_nxt[COL_W-1:0];
            end
        end
    end

    // Next values of the registered outputs; write fields hold when idle
    always_comb begin
        wr_en_d    = pixel_go;
        wr_frame_d = wr_frame_q;
        wr_row_d   = wr_row_q;
        wr_col_d   = wr_col_q;
        wr_rgb_d   = wr_rgb_q;
        if (pixel_go) begin
            wr_frame_d = target;
            wr_row_d   = row;
            wr_col_d   = col;
            wr_rgb_d   = ((state == CLEAR) && at_origin) ? bg_rgb : paint_rgb;
        end
        cmd_ready_d = (state == IDLE) && !swap && !(accept && !discard);
        busy_d      = (state_d != IDLE);
        aborted_d   = swap && (state == DRAW);
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_frame_q  <= 1'b0;
            wr_row_q    <= '0;
            wr_col_q    <= '0;
            wr_rgb_q    <= '0;
            busy_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            wr_en_q     <= wr_en_d;
            wr_frame_q  <= wr_frame_d;
            wr_row_q    <= wr_row_d;
            wr_col_q    <= wr_col_d;
            wr_rgb_q    <= wr_rgb_d;
            busy_q      <= busy_d;
            aborted_q   <= aborted_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_frame  = wr_frame_q;
    assign bus.wr_row    = wr_row_q;
    assign bus.wr_col    = wr_col_q;
    assign bus.wr_rgb    = wr_rgb_q;
    assign busy          = busy_q;
    assign cmd_aborted   = aborted_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_frame_painter.sv
// Directed bench for frame_painter: clear, fill, clip, discard, abort,
// reset mid-clear and swap/command collision.
module tb_frame_painter;
    import painter_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           active_frame;
    rgb444_t        bg_rgb;
    logic           busy;
    logic           cmd_aborted;
    painter_state_t dbg_state;

    frame_painter_if bus ();

    frame_painter dut (
        .clk          (clk),
        .rst          (rst),
        .active_frame (active_frame),
        .bg_rgb       (bg_rgb),
        .bus          (bus),
        .busy         (busy),
        .cmd_aborted  (cmd_aborted),
        .dbg_state    (dbg_state)
    );

    // 25 MHz pixel clock
    always #20 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Write records: {frame, row[6:0], col[7:0], rgb[11:0]}
    logic [27:0] exp_q[$];
    logic [27:0] obs_q[$];
    int          idx_q[$];
    int          ready_low;
    int          abort_cnt;
    logic        timed_out;

    // Expected writes of a row-major fill over [y0,y1) x [x0,x1)
    task automatic push_rect(input logic f, input int y0, input int y1,
                             input int x0, input int x1, input logic [11:0] rgb);
        for (int r = y0; r < y1; r++)
            for (int c = x0; c < x1; c++)
                exp_q.push_back({f, 7'(r), 8'(c), rgb});
    endtask

    // Number of differing entries between captured and expected writes
    function automatic int count_diff(output int first);
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        count_diff = 0;
        first = -1;
        for (int i = 0; i < n; i++) begin
            if (obs_q[i] !== exp_q[i]) begin
                count_diff++;
                if (first < 0) first = i;
            end
        end
    endfunction

    // Drive one command, held for exactly one rising edge
    task automatic send_cmd(input int x, input int y, input int w, input int h,
                            input logic [11:0] rgb);
        bus.cmd_x     = 8'(x);
        bus.cmd_y     = 8'(y);
        bus.cmd_w     = 8'(w);
        bus.cmd_h     = 8'(h);
        bus.cmd_rgb   = rgb;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Capture writes each negedge until cmd_ready is seen (after min_s samples)
    task automatic watch(input int min_s, input int max_s, input int toggle_at,
                         input int bg_at, input logic [11:0] bg_new);
        obs_q.delete();
        idx_q.delete();
        ready_low = 0;
        abort_cnt = 0;
        timed_out = 1'b0;
        for (int k = 0; k <= max_s; k++) begin
            if (k == max_s) begin
                timed_out = 1'b1;
                break;
            end
            if (bus.wr_en) begin
                obs_q.push_back({bus.wr_frame, bus.wr_row, bus.wr_col, bus.wr_rgb});
                idx_q.push_back(k);
            end
            if (cmd_aborted) abort_cnt++;
            if (!bus.cmd_ready) ready_low++;
            if (k == toggle_at) active_frame = ~active_frame;
            if (k == bg_at) bg_rgb = bg_new;
            if (bus.cmd_ready && (k + 1 >= min_s)) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        rst           = 1'b1;
        active_frame  = 1'b0;
        bg_rgb        = 12'h00F;
        bus.cmd_valid = 1'b0;
        bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0; bus.cmd_h = '0;
        bus.cmd_rgb = '0;
        repeat (3) @(negedge clk);
        outs = {bus.wr_en, bus.wr_frame, bus.wr_row, bus.wr_col, bus.wr_rgb,
                bus.cmd_ready, busy, cmd_aborted};
        tests_run++;
        if (outs !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h want 00000000", outs);
        end
        tests_run++;
        if (dbg_state !== CLEAR) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d want %0d", dbg_state, CLEAR);
        end
        rst = 1'b0;
    endtask

    task automatic test_initial_clear();
        int nd, first;
        exp_q.delete();
        push_rect(1'b1, 0, 120, 0, 160, 12'h00F);
        // bg changes after the clear has started and must not be picked up
        watch(1, 20000, -1, 5, 12'hFFF);
        nd = count_diff(first);
        tests_run++;
        if (timed_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_timeout: cmd_ready never rose");
        end
        tests_run++;
        if (obs_q.size() != 19200) begin
            tests_failed++;
            $display("FAIL clear_count: got %0d want 19200", obs_q.size());
        end
        tests_run++;
        if (nd != 0) begin
            tests_failed++;
            $display("FAIL clear_data: %0d differ, first #%0d got %h want %h", nd, first,
                     obs_q[first], exp_q[first]);
        end
        tests_run++;
        if ((obs_q.size() > 0 ? idx_q[0] : -1) != 1 ||
            (obs_q.size() > 0 ? idx_q[$] - idx_q[0] + 1 : -1) != obs_q.size()) begin
            tests_failed++;
            $display("FAIL clear_burst: first at %0d want 1, not contiguous over %0d writes",
                     (obs_q.size() > 0 ? idx_q[0] : -1), obs_q.size());
        end
        tests_run++;
        if ({bus.cmd_ready, busy} !== 2'b10) begin
            tests_failed++;
            $display("FAIL clear_done: ready,busy got %b want 10", {bus.cmd_ready, busy});
        end
    endtask

    task automatic test_rect();
        int nd, first;
        exp_q.delete();
        push_rect(1'b1, 5, 7, 10, 13, 12'hF00);
        send_cmd(10, 5, 3, 2, 12'hF00);
        watch(1, 100, -1, -1, 12'h0);
        nd = count_diff(first);
        tests_run++;
        if (timed_out !== 1'b0 || obs_q.size() != 6) begin
            tests_failed++;
            $display("FAIL rect_count: got %0d writes timeout=%b want 6", obs_q.size(), timed_out);
        end
        tests_run++;
        if (nd != 0) begin
            tests_failed++;
            $display("FAIL rect_data: %0d differ, first #%0d got %h want %h", nd, first,
                     obs_q[first], exp_q[first]);
        end
        tests_run++;
        if (ready_low != 7) begin
            tests_failed++;
            $display("FAIL rect_ready_low: got %0d cycles want 7", ready_low);
        end
        tests_run++;
        if ((obs_q.size() > 0 ? idx_q[0] : -1) != 1 ||
            (obs_q.size() > 0 ? idx_q[$] : -1) != 6) begin
            tests_failed++;
            $display("FAIL rect_timing: writes at %0d..%0d want 1..6",
                     (obs_q.size() > 0 ? idx_q[0] : -1), (obs_q.size() > 0 ? idx_q[$] : -1));
        end
        tests_run++;
        if (abort_cnt != 0) begin
            tests_failed++;
            $display("FAIL rect_abort: got %0d pulses want 0", abort_cnt);
        end
    endtask

    task automatic test_clip();
        int nd, first;
        exp_q.delete();
        push_rect(1'b1, 119, 120, 158, 160, 12'h0AB);
        send_cmd(158, 119, 10, 10, 12'h0AB);
        watch(1, 100, -1, -1, 12'h0);
        nd = count_diff(first);
        tests_run++;
        if (obs_q.size() != 2) begin
            tests_failed++;
            $display("FAIL clip_count: got %0d want 2", obs_q.size());
        end
        tests_run++;
        if (nd != 0) begin
            tests_failed++;
            $display("FAIL clip_data: %0d differ, first #%0d got %h want %h", nd, first,
                     obs_q[first], exp_q[first]);
        end
        tests_run++;
        if (ready_low != 3) begin
            tests_failed++;
            $display("FAIL clip_ready_low: got %0d want 3", ready_low);
        end
    endtask

    task automatic test_discard();
        int cmds[4][4];
        cmds[0] = '{20, 20, 0, 5};
        cmds[1] = '{20, 20, 5, 0};
        cmds[2] = '{200, 10, 5, 5};
        cmds[3] = '{10, 120, 5, 5};
        for (int i = 0; i < 4; i++) begin
            send_cmd(cmds[i][0], cmds[i][1], cmds[i][2], cmds[i][3], 12'h123);
            watch(6, 100, -1, -1, 12'h0);
            tests_run++;
            if (obs_q.size() != 0 || ready_low != 0) begin
                tests_failed++;
                $display("FAIL discard_%0d: got %0d writes, ready low %0d want 0 and 0",
                         i, obs_q.size(), ready_low);
            end
        end
        // Write fields still show the last clipped pixel
        tests_run++;
        if ({bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_rgb} !== {1'b0, 7'd119, 8'd159, 12'h0AB}) begin
            tests_failed++;
            $display("FAIL write_hold: got en=%b row=%0d col=%0d rgb=%h want 0,119,159,0ab",
                     bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_rgb);
        end
    endtask

    task automatic test_abort();
        int nd, first;
        bg_rgb = 12'h0F0;
        exp_q.delete();
        // 10 writes before the toggle plus 2 while it crosses the synchroniser
        push_rect(1'b1, 0, 1, 0, 12, 12'hC0C);
        push_rect(1'b0, 0, 120, 0, 160, 12'h0F0);
        send_cmd(0, 0, 50, 2, 12'hC0C);
        watch(1, 20000, 10, -1, 12'h0);
        nd = count_diff(first);
        tests_run++;
        if (timed_out !== 1'b0 || obs_q.size() != 19212) begin
            tests_failed++;
            $display("FAIL abort_count: got %0d writes timeout=%b want 19212", obs_q.size(), timed_out);
        end
        tests_run++;
        if (nd != 0) begin
            tests_failed++;
            $display("FAIL abort_data: %0d differ, first #%0d got %h want %h", nd, first,
                     obs_q[first], exp_q[first]);
        end
        tests_run++;
        if (abort_cnt != 1) begin
            tests_failed++;
            $display("FAIL abort_pulse: got %0d pulses want 1", abort_cnt);
        end
        tests_run++;
        if ((obs_q.size() > 12 ? idx_q[12] : -1) != 14 ||
            (obs_q.size() > 12 ? idx_q[$] - idx_q[12] : -1) != 19199) begin
            tests_failed++;
            $display("FAIL abort_clear_timing: first clear at %0d want 14, span %0d want 19199",
                     (obs_q.size() > 12 ? idx_q[12] : -1), (obs_q.size() > 12 ? idx_q[$] - idx_q[12] : -1));
        end
    endtask

    task automatic test_reset_mid_clear();
        int nd, first;
        logic [31:0] outs;
        active_frame = 1'b0;
        repeat (60) @(negedge clk);
        tests_run++;
        if ({busy, bus.wr_en, bus.wr_frame} !== 3'b111) begin
            tests_failed++;
            $display("FAIL midclear_active: busy,wr_en,frame got %b want 111",
                     {busy, bus.wr_en, bus.wr_frame});
        end
        rst          = 1'b1;
        active_frame = 1'b1;
        bg_rgb       = 12'h5A3;
        @(negedge clk);
        outs = {bus.wr_en, bus.wr_frame, bus.wr_row, bus.wr_col, bus.wr_rgb,
                bus.cmd_ready, busy, cmd_aborted};
        tests_run++;
        if (outs !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst2_outputs: got %h want 00000000", outs);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        push_rect(1'b1, 0, 1, 0, 2, 12'h5A3);
        push_rect(1'b0, 0, 120, 0, 160, 12'h5A3);
        watch(1, 20000, -1, -1, 12'h0);
        nd = count_diff(first);
        tests_run++;
        if (timed_out !== 1'b0 || obs_q.size() != 19202) begin
            tests_failed++;
            $display("FAIL rst2_count: got %0d writes timeout=%b want 19202", obs_q.size(), timed_out);
        end
        tests_run++;
        if (nd != 0) begin
            tests_failed++;
            $display("FAIL rst2_data: %0d differ, first #%0d got %h want %h", nd, first,
                     obs_q[first], exp_q[first]);
        end
        tests_run++;
        if ((obs_q.size() > 2 ? idx_q[2] : -1) != 4) begin
            tests_failed++;
            $display("FAIL rst2_restart: frame 0 clear began at %0d want 4",
                     (obs_q.size() > 2 ? idx_q[2] : -1));
        end
        tests_run++;
        if (abort_cnt != 0) begin
            tests_failed++;
            $display("FAIL rst2_abort: got %0d pulses want 0", abort_cnt);
        end
    endtask

    task automatic test_swap_vs_cmd();
        int nd, first;
        bg_rgb       = 12'h777;
        active_frame = 1'b0;
        repeat (2) @(negedge clk);
        // The swap is pending now; offer a command in this very cycle
        bus.cmd_x = 8'd1; bus.cmd_y = 8'd1; bus.cmd_w = 8'd2; bus.cmd_h = 8'd1;
        bus.cmd_rgb   = 12'hABC;
        bus.cmd_valid = 1'b1;
        tests_run++;
        if (bus.cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL swapcmd_ready_before: got %b want 1", bus.cmd_ready);
        end
        @(negedge clk);
        tests_run++;
        if ({bus.cmd_ready, dbg_state} !== {1'b0, CLEAR}) begin
            tests_failed++;
            $display("FAIL swapcmd_not_taken: ready=%b state=%0d want 0,%0d",
                     bus.cmd_ready, dbg_state, CLEAR);
        end
        exp_q.delete();
        push_rect(1'b1, 0, 120, 0, 160, 12'h777);
        watch(1, 20000, -1, -1, 12'h0);
        nd = count_diff(first);
        tests_run++;
        if (timed_out !== 1'b0 || obs_q.size() != 19200 || nd != 0) begin
            tests_failed++;
            $display("FAIL swapcmd_clear: got %0d writes, %0d differ, timeout=%b want 19200,0,0",
                     obs_q.size(), nd, timed_out);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        exp_q.delete();
        push_rect(1'b1, 1, 2, 1, 3, 12'hABC);
        watch(1, 100, -1, -1, 12'h0);
        nd = count_diff(first);
        tests_run++;
        if (obs_q.size() != 2 || nd != 0 || ready_low != 3) begin
            tests_failed++;
            $display("FAIL swapcmd_late_accept: got %0d writes, %0d differ, ready low %0d want 2,0,3",
                     obs_q.size(), nd, ready_low);
        end
    endtask

    initial begin
        test_reset();
        test_initial_clear();
        test_rect();
        test_clip();
        test_discard();
        test_abort();
        test_reset_mid_clear();
        test_swap_vs_cmd();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
